pipelined_mux_n_to_1: RTL and testbench

Parametrised N-input selector with a registered, stallable and flushable output pipeline. It is the successor to the fixed 3-to-1 combinational datapath mux. It sits at pipeline-register boundaries, for example PC source selection (PC+4, branch target, jump target, jr register) or ALU operand forwarding, where the selected value must be registered with the stage's stall and flush controls. It adds a valid bit per stage and sticky detection of out-of-range selector codes.

---
 rtl/pipelined_mux_n_to_1_pkg.sv | 31 +++
 rtl/pipelined_mux_n_to_1_pipe_stage_reg.sv | 53 +++++
 rtl/pipelined_mux_n_to_1.sv | 114 +++++++++++
 tb/tb_pipelined_mux_n_to_1.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_mux_n_to_1_pkg.sv
// Shared constants, helpers and parameter checks for the pipelined N-to-1 selector.
// Latency: none (package only).
// Backpressure: none (package only).
//
// Contents:
//   MaxStages / MinInputs / MaxInputs : legal parameter limits
//   clog2_f                           : ceil-log2, used to derive the minimum selector width
//   PMUX_CHECK                        : elaboration-time parameter check macro

`define PMUX_CHECK(cond_, label_, msg_) \
    if (!(cond_)) begin : label_ \
        $error(msg_); \
    end

package pipelined_mux_n_to_1_pkg;

    localparam int unsigned MaxStages = 4;
    localparam int unsigned MinInputs = 2;
    localparam int unsigned MaxInputs = 16;

    // Smallest r with 2**r >= value; clog2_f(1) == 0.
    function automatic int unsigned clog2_f(input int unsigned value);
        int unsigned r;
        r = 0;
        while ((32'd1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipelined_mux_n_to_1_pipe_stage_reg.sv
// One {valid, data} pipeline register with hold and synchronous flush.
// Latency: 1 clock edge from vld_i/dat_i to vld_o/dat_o when en_i=1.
// Backpressure: en_i=0 holds contents; flush_i=1 clears them and overrides en_i.
//
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset (clears valid and data)
//   en_i, flush_i     : advance / clear controls
//   vld_i, dat_i      : next entry from the previous stage
//   vld_o, dat_o      : registered entry

module pipelined_mux_n_to_1_pipe_stage_reg #(
    parameter int unsigned NBits = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             vld_i,
    input  logic [NBits-1:0] dat_i,
    output logic             vld_o,
    output logic [NBits-1:0] dat_o
);

    logic             vld_q, vld_d;
    logic [NBits-1:0] dat_q, dat_d;

    // Flush beats enable; data is captured regardless of the valid bit.
    always_comb begin
        vld_d = vld_q;
        dat_d = dat_q;
        if (flush_i) begin
            vld_d = 1'b0;
            dat_d = '0;
        end else if (en_i) begin
            vld_d = vld_i;
            dat_d = dat_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= 1'b0;
            dat_q <= '0;
        end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
        end
    end

    assign vld_o = vld_q;
    assign dat_o = dat_q;

endmodule

// File: rtl/pipelined_mux_n_to_1.sv
// Parametrised N-to-1 selector feeding a registered, stallable, flushable pipe with sticky bad-selector flag.
// Latency: Stages clock edges with Enable_i=1; one sample per cycle, no bubbles.
// Backpressure: Enable_i=0 freezes every stage; Flush_i clears every stage and wins over Enable_i.
//
// Ports:
//   clk, reset                  : clock, asynchronous active-low reset
//   Enable_i, Flush_i           : pipe advance / synchronous clear
//   Valid_i, Selector_i         : sample qualifier and input index
//   Mux_Data_i                  : flattened inputs, input k at [k*NBits +: NBits]
//   Error_Clear_i               : clears Sel_Error_o (a same-cycle new error wins)
//   Mux_Output_o, Valid_o       : last pipe stage
//   Sel_Error_o                 : sticky, set when an out-of-range selector is accepted

module pipelined_mux_n_to_1
    import pipelined_mux_n_to_1_pkg::*;
#(
    parameter int unsigned     NBits        = 32,
    parameter int unsigned     NInputs      = 4,
    parameter int unsigned     SelBits      = 2,
    parameter int unsigned     Stages       = 1,
    parameter logic [NBits-1:0] DefaultValue = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       Enable_i,
    input  logic                       Flush_i,
    input  logic                       Valid_i,
    input  logic [SelBits-1:0]         Selector_i,
    input  logic [NInputs*NBits-1:0]   Mux_Data_i,
    input  logic                       Error_Clear_i,
    output logic [NBits-1:0]           Mux_Output_o,
    output logic                       Valid_o,
    output logic                       Sel_Error_o
);

    localparam int unsigned MinSelBits = clog2_f(NInputs);

    `PMUX_CHECK(NInputs >= MinInputs && NInputs <= MaxInputs, g_chk_ninputs, "NInputs must be in 2..16")
    `PMUX_CHECK(Stages >= 1 && Stages <= MaxStages, g_chk_stages, "Stages must be in 1..4")
    `PMUX_CHECK(SelBits >= MinSelBits, g_chk_selbits, "SelBits too narrow for NInputs")

    // ---------------- selector ----------------
    logic [NBits-1:0] sel_data;

    always_comb begin
        sel_data = DefaultValue;
        for (int k = 0; k < int'(NInputs); k++) begin
            if (Selector_i == SelBits'(k)) begin
                sel_data = Mux_Data_i[k*NBits +: NBits];
            end
        end
    end

    // When every selector code maps to an input there is nothing to flag.
    logic sel_oor;
    if (NInputs == (32'd1 << SelBits)) begin : g_full_range
        assign sel_oor = 1'b0;
    end else begin : g_partial_range
        assign sel_oor = (Selector_i >= SelBits'(NInputs));
    end

    // ---------------- pipe ----------------
    logic             vld_chain [Stages+1];
    logic [NBits-1:0] dat_chain [Stages+1];

    assign vld_chain[0] = Valid_i;
    assign dat_chain[0] = sel_data;

    for (genvar g = 0; g < int'(Stages); g++) begin : g_stage
        pipelined_mux_n_to_1_pipe_stage_reg #(
            .NBits (NBits)
        ) u_stage (
            .clk     (clk),
            .rst_n   (reset),
            .en_i    (Enable_i),
            .flush_i (Flush_i),
            .vld_i   (vld_chain[g]),
            .dat_i   (dat_chain[g]),
            .vld_o   (vld_chain[g+1]),
            .dat_o   (dat_chain[g+1])
        );
    end

    assign Mux_Output_o = dat_chain[Stages];
    assign Valid_o      = vld_chain[Stages];

    // ---------------- sticky error ----------------
    // Only a sample that actually enters the pipe can raise the flag; flush leaves it alone.
    logic err_q, err_d;
    logic accept;

    assign accept = Valid_i & Enable_i & ~Flush_i;

    always_comb begin
        err_d = err_q;
        if (Error_Clear_i) begin
            err_d = 1'b0;
        end
        if (accept && sel_oor) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign Sel_Error_o = err_q;

endmodule

// File: tb/tb_pipelined_mux_n_to_1.sv
// Self-checking bench: three instances (4-in/1-stage, 4-in/3-stage, 3-in/2-stage with default 0xDEAD)
// share one stimulus stream and are compared against a queue-based behavioural model.
// Scenario tasks cover reset, latency, stall/flush, out-of-range, clear race, random traffic, async reset.

module tb_pipelined_mux_n_to_1;

    localparam int NB = 32;
    localparam int NI [3] = '{4, 4, 3};
    localparam int ST [3] = '{1, 3, 2};
    localparam logic [31:0] DV [3] = '{32'h0, 32'h0, 32'hDEAD};

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         en = 1'b0;
    logic         flush = 1'b0;
    logic         valid = 1'b0;
    logic [1:0]   sel = 2'd0;
    logic         clr = 1'b0;
    logic [127:0] data_bus = '0;

    logic [31:0] out_a, out_b, out_c;
    logic        v_a, v_b, v_c, e_a, e_b, e_c;

    logic [31:0] dout [3];
    logic        vout [3];
    logic        eout [3];

    assign dout[0] = out_a; assign dout[1] = out_b; assign dout[2] = out_c;
    assign vout[0] = v_a;   assign vout[1] = v_b;   assign vout[2] = v_c;
    assign eout[0] = e_a;   assign eout[1] = e_b;   assign eout[2] = e_c;

    always #5 clk = ~clk;

    pipelined_mux_n_to_1 #(.NBits(NB), .NInputs(4), .SelBits(2), .Stages(1), .DefaultValue(32'h0)) u_s1 (
        .clk(clk), .reset(reset), .Enable_i(en), .Flush_i(flush), .Valid_i(valid),
        .Selector_i(sel), .Mux_Data_i(data_bus), .Error_Clear_i(clr),
        .Mux_Output_o(out_a), .Valid_o(v_a), .Sel_Error_o(e_a));

    pipelined_mux_n_to_1 #(.NBits(NB), .NInputs(4), .SelBits(2), .Stages(3), .DefaultValue(32'h0)) u_s3 (
        .clk(clk), .reset(reset), .Enable_i(en), .Flush_i(flush), .Valid_i(valid),
        .Selector_i(sel), .Mux_Data_i(data_bus), .Error_Clear_i(clr),
        .Mux_Output_o(out_b), .Valid_o(v_b), .Sel_Error_o(e_b));

    pipelined_mux_n_to_1 #(.NBits(NB), .NInputs(3), .SelBits(2), .Stages(2), .DefaultValue(32'hDEAD)) u_oor (
        .clk(clk), .reset(reset), .Enable_i(en), .Flush_i(flush), .Valid_i(valid),
        .Selector_i(sel), .Mux_Data_i(data_bus[95:0]), .Error_Clear_i(clr),
        .Mux_Output_o(out_c), .Valid_o(v_c), .Sel_Error_o(e_c));

    // ---------------- behavioural model ----------------
    // Each instance is a queue of {valid,data}; the newest entry is at the front, the output at the back.
    logic [32:0] mq [3][$];
    logic        err_m [3];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            for (int s = 0; s < ST[i]; s++) mq[i].push_back(33'h0);
            err_m[i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [31:0] sv;
        logic [32:0] dropped;
        int          s;
        if (!reset) return;
        s = int'(sel);
        for (int i = 0; i < 3; i++) begin
            sv = (s < NI[i]) ? data_bus[s*32 +: 32] : DV[i];
            if (flush) begin
                for (int k = 0; k < ST[i]; k++) mq[i][k] = 33'h0;
            end else if (en) begin
                mq[i].push_front({valid, sv});
                dropped = mq[i].pop_back();
            end
            if (valid && en && !flush && s >= NI[i]) err_m[i] = 1'b1;
            else if (clr) err_m[i] = 1'b0;
        end
    endtask

    // Inputs are only changed right after this returns, so they are stable at the edge.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        data_bus = {32'h0, 32'h44, 32'h33, 32'h22, 32'h11};
        data_bus[127:96] = 32'h44;
        data_bus[95:0]   = {32'h33, 32'h22, 32'h11};
        valid = 1'b1; en = 1'b1; sel = 2'd2;
        repeat (2) tick();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dout[i] !== 32'h0 || vout[i] !== 1'b0 || eout[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_hold inst%0d: got data=%h v=%b e=%b, want 0/0/0", i, dout[i], vout[i], eout[i]);
            end
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (dout[0] !== 32'h33 || vout[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_first: got data=%h v=%b, want 33/1", dout[0], vout[0]);
        end
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if ({vout[i], dout[i]} !== mq[i][$] || eout[i] !== err_m[i]) begin
                n_fail++;
                $display("FAIL reset_release_model inst%0d: got %h e=%b, want %h e=%b", i, {vout[i], dout[i]}, eout[i], mq[i][$], err_m[i]);
            end
        end
    endtask

    task automatic test_latency();
        logic [1:0]  seq [4];
        logic [31:0] exp_out [4];
        int          vcount;
        seq = '{2'd0, 2'd1, 2'd3, 2'd2};
        exp_out = '{32'h11, 32'h22, 32'h44, 32'h33};
        flush = 1'b1; clr = 1'b1; tick(); flush = 1'b0; clr = 1'b0;
        vcount = 0;
        for (int t = 0; t < 10; t++) begin
            if (t < 4) begin valid = 1'b1; sel = seq[t]; end
            else begin valid = 1'b0; sel = 2'($urandom_range(0, 3)); end
            tick();
            if (vout[1]) vcount++;
            if (t >= 2 && t <= 5) begin
                n_tests++;
                if (dout[1] !== exp_out[t-2] || vout[1] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL latency_s3 edge%0d: got data=%h v=%b, want %h/1", t + 1, dout[1], vout[1], exp_out[t-2]);
                end
            end
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({vout[i], dout[i]} !== mq[i][$] || eout[i] !== err_m[i]) begin
                    n_fail++;
                    $display("FAIL latency_model inst%0d edge%0d: got %h e=%b, want %h e=%b", i, t + 1, {vout[i], dout[i]}, eout[i], mq[i][$], err_m[i]);
                end
            end
        end
        n_tests++;
        if (vcount != 4) begin
            n_fail++;
            $display("FAIL latency_valid_count: got %0d valid cycles, want 4", vcount);
        end
    endtask

    task automatic test_stall_flush();
        flush = 1'b1; tick(); flush = 1'b0;
        en = 1'b1; valid = 1'b1;
        sel = 2'd0; tick();
        sel = 2'd1; tick();
        en = 1'b0; sel = 2'd2;
        for (int t = 0; t < 3; t++) begin
            tick();
            n_tests++;
            if (dout[2] !== 32'h11 || vout[2] !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_hold cycle%0d: got data=%h v=%b, want 11/1", t, dout[2], vout[2]);
            end
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({vout[i], dout[i]} !== mq[i][$]) begin
                    n_fail++;
                    $display("FAIL stall_model inst%0d: got %h, want %h", i, {vout[i], dout[i]}, mq[i][$]);
                end
            end
        end
        flush = 1'b1; tick(); flush = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dout[i] !== 32'h0 || vout[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_while_stalled inst%0d: got data=%h v=%b, want 0/0", i, dout[i], vout[i]);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_out_of_range();
        clr = 1'b1; valid = 1'b0; tick(); clr = 1'b0;
        valid = 1'b1; en = 1'b1; sel = 2'd3;
        tick();
        n_tests++;
        if (eout[2] !== 1'b1 || eout[0] !== 1'b0 || eout[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_flag: got e=%b%b%b, want oor=1 full-range=0", eout[0], eout[1], eout[2]);
        end
        valid = 1'b0; sel = 2'd0;
        tick();
        n_tests++;
        if (dout[2] !== 32'hDEAD || vout[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL oor_default: got data=%h v=%b, want dead/1", dout[2], vout[2]);
        end
        clr = 1'b1; tick(); clr = 1'b0;
        valid = 1'b0; sel = 2'd3; tick();
        n_tests++;
        if (eout[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_invalid_no_set: got e=%b, want 0", eout[2]);
        end
        valid = 1'b1; en = 1'b0; tick();
        n_tests++;
        if (eout[2] !== 1'b0 || err_m[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL oor_stalled_no_set: got e=%b, want 0", eout[2]);
        end
        en = 1'b1; valid = 1'b0;
    endtask

    task automatic test_clear_race();
        valid = 1'b1; en = 1'b1; sel = 2'd3; tick();
        clr = 1'b1; tick();
        n_tests++;
        if (eout[2] !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_race_set_wins: got e=%b, want 1", eout[2]);
        end
        valid = 1'b0; tick(); clr = 1'b0;
        n_tests++;
        if (eout[2] !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_alone: got e=%b, want 0", eout[2]);
        end
    endtask

    task automatic test_random();
        for (int t = 0; t < 400; t++) begin
            en    = ($urandom_range(0, 3) != 0);
            flush = ($urandom_range(0, 15) == 0);
            valid = $urandom_range(0, 1) == 1;
            clr   = ($urandom_range(0, 7) == 0);
            sel   = 2'($urandom_range(0, 3));
            data_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({vout[i], dout[i]} !== mq[i][$] || eout[i] !== err_m[i]) begin
                    n_fail++;
                    $display("FAIL random inst%0d cycle%0d: got %h e=%b, want %h e=%b", i, t, {vout[i], dout[i]}, eout[i], mq[i][$], err_m[i]);
                end
            end
        end
        flush = 1'b0; clr = 1'b0; en = 1'b1;
    endtask

    task automatic test_async_reset();
        valid = 1'b1; en = 1'b1;
        for (int t = 0; t < 4; t++) begin
            sel = 2'($urandom_range(0, 3));
            data_bus = {$urandom(), $urandom(), $urandom(), $urandom()};
            tick();
        end
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            n_tests++;
            if (dout[i] !== 32'h0 || vout[i] !== 1'b0 || eout[i] !== 1'b0) begin
                n_fail++;
                $display("FAIL async_reset inst%0d: got data=%h v=%b e=%b, want 0/0/0", i, dout[i], vout[i], eout[i]);
            end
        end
        @(posedge clk); #1;
        reset = 1'b1;
        for (int t = 0; t < 5; t++) begin
            sel = 2'($urandom_range(0, 3));
            valid = $urandom_range(0, 1) == 1;
            tick();
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({vout[i], dout[i]} !== mq[i][$] || eout[i] !== err_m[i]) begin
                    n_fail++;
                    $display("FAIL after_async_reset inst%0d cycle%0d: got %h e=%b, want %h e=%b", i, t, {vout[i], dout[i]}, eout[i], mq[i][$], err_m[i]);
                end
            end
        end
    endtask

    initial begin
        model_reset();
        #1;
        test_reset();
        test_latency();
        test_stall_flush();
        test_out_of_range();
        test_clear_race();
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
